// File: rtl/affine_sbmv_gen_if.sv
// affine_sbmv_gen_if: CPMV request and subblock motion-vector stream for the affine MV generator
interface affine_sbmv_gen_if #(parameter int MV_W = 13);
  logic start;
  logic six_param;
  logic signed [MV_W-1:0] mvLT_x, mvLT_y, mvRT_x, mvRT_y, mvLB_x, mvLB_y;
  logic [8:0] Ipu_w, Ipu_h;
  logic sb_ready;
  logic sb_valid;
  logic [4:0] sb_x, sb_y;
  logic signed [MV_W-1:0] sb_mv_x, sb_mv_y;
  logic sb_last;
  logic busy;
  logic done;
  modport master (
    output start, six_param, mvLT_x, mvLT_y, mvRT_x, mvRT_y, mvLB_x, mvLB_y, Ipu_w, Ipu_h, sb_ready,
    input  sb_valid, sb_x, sb_y, sb_mv_x, sb_mv_y, sb_last, busy, done
  );
  modport slave (
    input  start, six_param, mvLT_x, mvLT_y, mvRT_x, mvRT_y, mvLB_x, mvLB_y, Ipu_w, Ipu_h, sb_ready,
    output sb_valid, sb_x, sb_y, sb_mv_x, sb_mv_y, sb_last, busy, done
  );
endinterface

// File: rtl/affine_sbmv_gen.sv
// affine_sbmv_gen: per-4x4-subblock affine motion vectors from control-point MVs, streamed in raster order
module affine_sbmv_gen #(
  parameter int MV_W  = 13,
  parameter int ACC_W = 24
) (
  input logic clk,
  input logic rst_n,
  affine_sbmv_gen_if.slave sb
);
  typedef enum logic [1:0] {IDLE, SETUP, EMIT, FIN} state_t;
  localparam logic signed [ACC_W-1:0] MV_MAX = ACC_W'((1 << (MV_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MV_MIN = -MV_MAX - ACC_W'(1);
  function automatic logic signed [ACC_W-1:0] sx(input logic signed [MV_W-1:0] v);
    return {{(ACC_W - MV_W){v[MV_W-1]}}, v};
  endfunction
  function automatic logic [2:0] log2p(input logic [8:0] v);
    logic [2:0] l;
    l = '0;
    for (int i = 0; i < 9; i++) if (v[i]) l = 3'(i);
    return l;
  endfunction
  function automatic logic signed [MV_W-1:0] to_mv(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] m, r;
    m = v[ACC_W-1] ? -v : v;
    r = (m + ACC_W'(64)) >> 7;
    r = v[ACC_W-1] ? -r : r;
    r = (r > MV_MAX) ? MV_MAX : (r < MV_MIN) ? MV_MIN : r;
    return r[MV_W-1:0];
  endfunction
  state_t r_state, w_state_nxt;
  logic r_six;
  logic signed [MV_W-1:0] r_ltx, r_lty, r_rtx, r_rty, r_lbx, r_lby;
  logic [2:0] r_l2w, r_l2h;
  logic signed [ACC_W-1:0] r_accx, r_accy, r_rowx, r_rowy;
  logic [4:0] r_x, r_y;
  logic signed [MV_W-1:0] r_mvx, r_mvy;
  logic r_valid, r_last, r_busy, r_done;
  logic [4:0] w_wm1, w_hm1, w_nx, w_ny;
  logic signed [ACC_W-1:0] w_dhx, w_dhy, w_dvx, w_dvy, w_initx, w_inity;
  logic signed [ACC_W-1:0] w_rowx_nxt, w_rowy_nxt, w_accx_nxt, w_accy_nxt;
  logic w_hs, w_eol, w_adv;
  // affine gradients from latched CPMVs, raster stepping of the accumulators, and next FSM state
  always_comb begin
    w_dhx = (sx(r_rtx) - sx(r_ltx)) <<< (3'd7 - r_l2w);
    w_dhy = (sx(r_rty) - sx(r_lty)) <<< (3'd7 - r_l2w);
    w_dvx = r_six ? (sx(r_lbx) - sx(r_ltx)) <<< (3'd7 - r_l2h) : -w_dhy;
    w_dvy = r_six ? (sx(r_lby) - sx(r_lty)) <<< (3'd7 - r_l2h) : w_dhx;
    w_initx = (sx(r_ltx) <<< 7) + (w_dhx <<< 1) + (w_dvx <<< 1);
    w_inity = (sx(r_lty) <<< 7) + (w_dhy <<< 1) + (w_dvy <<< 1);
    w_wm1 = 5'((6'd1 << (r_l2w - 3'd2)) - 6'd1);
    w_hm1 = 5'((6'd1 << (r_l2h - 3'd2)) - 6'd1);
    w_hs = r_valid && sb.sb_ready;
    w_adv = w_hs && !r_last;
    w_eol = r_x == w_wm1;
    w_nx = w_eol ? 5'd0 : r_x + 5'd1;
    w_ny = w_eol ? r_y + 5'd1 : r_y;
    w_rowx_nxt = w_eol ? r_rowx + (w_dvx <<< 2) : r_rowx;
    w_rowy_nxt = w_eol ? r_rowy + (w_dvy <<< 2) : r_rowy;
    w_accx_nxt = w_eol ? w_rowx_nxt : r_accx + (w_dhx <<< 2);
    w_accy_nxt = w_eol ? w_rowy_nxt : r_accy + (w_dhy <<< 2);
    w_state_nxt = (r_state == IDLE && sb.start) ? SETUP :
                  (r_state == SETUP) ? EMIT :
                  (r_state == EMIT && w_hs && r_last) ? FIN :
                  (r_state == FIN) ? IDLE : r_state;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // input latch, accumulator init/stepping and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_six <= 1'b0;
      {r_ltx, r_lty, r_rtx, r_rty, r_lbx, r_lby} <= '0;
      {r_l2w, r_l2h} <= '0;
      {r_accx, r_accy, r_rowx, r_rowy} <= '0;
      {r_x, r_y, r_mvx, r_mvy} <= '0;
      {r_valid, r_last, r_busy, r_done} <= '0;
    end else begin
      if (r_state == IDLE && sb.start) begin
        r_six <= sb.six_param;
        {r_ltx, r_lty, r_rtx, r_rty, r_lbx, r_lby} <= {sb.mvLT_x, sb.mvLT_y, sb.mvRT_x, sb.mvRT_y, sb.mvLB_x, sb.mvLB_y};
        r_l2w <= log2p(sb.Ipu_w);
        r_l2h <= log2p(sb.Ipu_h);
        r_busy <= 1'b1;
      end
      if (r_state == SETUP) begin
        {r_accx, r_rowx, r_accy, r_rowy} <= {w_initx, w_initx, w_inity, w_inity};
        {r_x, r_y} <= '0;
        r_mvx <= to_mv(w_initx);
        r_mvy <= to_mv(w_inity);
        r_valid <= 1'b1;
        r_last <= 1'b0;
      end
      if (w_adv) begin
        {r_x, r_y} <= {w_nx, w_ny};
        {r_accx, r_rowx, r_accy, r_rowy} <= {w_accx_nxt, w_rowx_nxt, w_accy_nxt, w_rowy_nxt};
        r_mvx <= to_mv(w_accx_nxt);
        r_mvy <= to_mv(w_accy_nxt);
        r_last <= (w_nx == w_wm1) && (w_ny == w_hm1);
      end
      if (w_hs && r_last) {r_valid, r_last, r_busy} <= '0;
      r_done <= w_hs && r_last;
    end
  end
  assign sb.sb_valid = r_valid;
  assign sb.sb_x = r_x;
  assign sb.sb_y = r_y;
  assign sb.sb_mv_x = r_mvx;
  assign sb.sb_mv_y = r_mvy;
  assign sb.sb_last = r_last;
  assign sb.busy = r_busy;
  assign sb.done = r_done;
endmodule

// File: tb/tb_affine_sbmv_gen.sv
// tb_affine_sbmv_gen: table-driven scoreboard bench for the affine subblock MV generator
module tb_affine_sbmv_gen;
  typedef struct packed {
    logic six;
    logic [12:0] ltx, lty, rtx, rty, lbx, lby;
    logic [8:0] w, h;
    logic [3:0] n;
    logic [7:0][12:0] ex;
    logic [7:0][12:0] ey;
  } vec_t;
  typedef struct packed {
    logic [4:0] x, y;
    logic [12:0] mx, my;
    logic last;
  } sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  bit rnd_ready = 1'b0;
  sb_t q[$];
  vec_t tbl[5];
  affine_sbmv_gen_if #(.MV_W(13)) bus();
  affine_sbmv_gen #(.MV_W(13), .ACC_W(24)) dut (.clk(clk), .rst_n(rst_n), .sb(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic vec_t mk(input bit six, input int ltx, lty, rtx, rty, lbx, lby, w, h, n);
    vec_t v;
    v = '0;
    v.six = six;
    v.ltx = 13'(ltx); v.lty = 13'(lty);
    v.rtx = 13'(rtx); v.rty = 13'(rty);
    v.lbx = 13'(lbx); v.lby = 13'(lby);
    v.w = 9'(w); v.h = 9'(h); v.n = 4'(n);
    return v;
  endfunction

  task automatic ex(input int i, input int k, input int x, input int y);
    tbl[i].ex[k] = 13'(x);
    tbl[i].ey[k] = 13'(y);
  endtask

  task automatic scramble();
    bus.six_param = 1'($urandom);
    bus.mvLT_x = 13'($urandom); bus.mvLT_y = 13'($urandom);
    bus.mvRT_x = 13'($urandom); bus.mvRT_y = 13'($urandom);
    bus.mvLB_x = 13'($urandom); bus.mvLB_y = 13'($urandom);
    bus.Ipu_w = 9'(8 << $urandom_range(0, 4));
    bus.Ipu_h = 9'(8 << $urandom_range(0, 4));
  endtask

  task automatic launch(input vec_t v);
    for (int y = 0; y < int'(v.h) / 4; y++)
      for (int x = 0; x < int'(v.w) / 4; x++) begin
        sb_t s;
        int k;
        k = y * (int'(v.w) / 4) + x;
        s.x = 5'(x);
        s.y = 5'(y);
        s.mx = v.ex[k % int'(v.n)];
        s.my = v.ey[k % int'(v.n)];
        s.last = (x == int'(v.w) / 4 - 1) && (y == int'(v.h) / 4 - 1);
        q.push_back(s);
      end
    @(negedge clk);
    bus.six_param = v.six;
    bus.mvLT_x = v.ltx; bus.mvLT_y = v.lty;
    bus.mvRT_x = v.rtx; bus.mvRT_y = v.rty;
    bus.mvLB_x = v.lbx; bus.mvLB_y = v.lby;
    bus.Ipu_w = v.w; bus.Ipu_h = v.h;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
  endtask

  task automatic run(input vec_t v, input bit rnd, input bit restart);
    int d0, t, n;
    n = (int'(v.w) / 4) * (int'(v.h) / 4);
    rnd_ready = rnd;
    d0 = done_cnt;
    launch(v);
    chk("busy after start", bus.busy, 1);
    if (restart) begin
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("done once", done_cnt - d0, 1);
    if (!rnd) chk("start-to-done latency", done_cyc - start_cyc, 2 + n);
    chk("queue drained", q.size(), 0);
    chk("idle outputs", {bus.busy, bus.sb_valid, bus.sb_last, bus.done}, 0);
  endtask

  // stream monitor: drives sb_ready, pops the scoreboard on each handshake, counts done pulses
  initial begin
    sb_t got, want;
    bus.sb_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.sb_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("queue empty at done", q.size(), 0);
      end
      if (bus.sb_valid && bus.sb_ready) begin
        got = {bus.sb_x, bus.sb_y, bus.sb_mv_x, bus.sb_mv_y, bus.sb_last};
        want = '1;
        if (q.size() > 0) want = q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL subblock: got (%0d,%0d) mv=(%0d,%0d) last=%0d, expected (%0d,%0d) mv=(%0d,%0d) last=%0d queued=%0d",
                   got.x, got.y, $signed(got.mx), $signed(got.my), got.last,
                   want.x, want.y, $signed(want.mx), $signed(want.my), want.last, q.size());
        end
      end
    end
  end

  initial begin
    int d0;
    bus.start = 1'b0;
    scramble();
    tbl[0] = mk(0, -92, -20, -92, -20, -92, -20, 128, 128, 1);
    ex(0, 0, -92, -20);
    tbl[1] = mk(0, 0, 0, 16, 0, 0, 0, 8, 8, 4);
    ex(1, 0, 4, 4); ex(1, 1, 12, 4); ex(1, 2, 4, 12); ex(1, 3, 12, 12);
    tbl[2] = mk(1, 0, 0, 0, 0, 0, 32, 16, 8, 8);
    for (int k = 0; k < 8; k++) ex(2, k, 0, k < 4 ? 8 : 24);
    tbl[3] = mk(0, 0, 0, -3, 0, 0, 0, 8, 8, 4);
    ex(3, 0, -1, -1); ex(3, 1, -2, -1); ex(3, 2, -1, -2); ex(3, 3, -2, -2);
    tbl[4] = mk(0, 4000, 0, 4000, -200, 0, 0, 8, 8, 4);
    ex(4, 0, 4050, -50); ex(4, 1, 4050, -150); ex(4, 2, 4095, -50); ex(4, 3, 4095, -150);
    repeat (2) @(negedge clk);
    chk("reset outputs", {bus.sb_valid, bus.sb_last, bus.busy, bus.done, bus.sb_x, bus.sb_y, bus.sb_mv_x, bus.sb_mv_y}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) run(tbl[i], 1'b0, 1'b0);
    run(tbl[1], 1'b1, 1'b0);
    run(tbl[2], 1'b1, 1'b1);
    rnd_ready = 1'b0;
    launch(tbl[0]);
    repeat (20) @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 chk("async reset valid/busy", {bus.sb_valid, bus.busy}, 0);
    chk("async reset position", {bus.sb_x, bus.sb_y, bus.sb_mv_x, bus.sb_mv_y}, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no done after abort", done_cnt - d0, 0);
    run(tbl[1], 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/affine_sbmv_gen.md
# affine_sbmv_gen

Subblock motion-vector generator for the H.266 affine prediction path. Takes the control-point motion vectors (CPMVs) and the size of one prediction block. Produces one rounded, clipped motion vector per 4x4 luma subblock, in raster order, over a valid/ready stream. It feeds the affine interpolation/cost stage inside `affine_top`, which accumulates the affine RD cost against `rd_cost_me`. CPMVs arrive in the same 1/16-pel 13-bit signed format used at `affine_top`.

## Interface
Parameters
- `MV_W`, 13: CPMV and output MV width (signed).
- `ACC_W`, 24: internal accumulator width (signed, 7 fractional bits).

Ports
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: sampled only in IDLE; latches all inputs below.
- `six_param` in 1: 1 = 6-parameter model (uses LB), 0 = 4-parameter model.
- `mvLT_x`, `mvLT_y`, `mvRT_x`, `mvRT_y`, `mvLB_x`, `mvLB_y` in MV_W signed: CPMVs.
- `Ipu_w`, `Ipu_h` in 9: block width/height, power of two, 8..128.
- `sb_ready` in 1: consumer accepts the current subblock.
- `sb_valid` out 1: subblock MV valid.
- `sb_x`, `sb_y` out 5: subblock column/row index (0..31).
- `sb_mv_x`, `sb_mv_y` out MV_W signed: subblock MV.
- `sb_last` out 1: marks final subblock (`sb_x`=W/4-1, `sb_y`=H/4-1).
- `busy` out 1: high from SETUP through the last handshake.
- `done` out 1: one-cycle pulse after the last handshake.

## Operation
- FSM states: IDLE, SETUP, EMIT, FIN.
  - IDLE --start--> SETUP (one cycle).
  - SETUP --> EMIT.
  - EMIT stays while subblocks remain; the handshake on the `sb_last` subblock --> FIN.
  - FIN --> IDLE; `done`=1 in FIN only.
- `start` outside IDLE is ignored. Input changes after the latch cycle are ignored.
- Log2 size: log2W/log2H is taken from the highest set bit of `Ipu_w`/`Ipu_h`.
- SETUP arithmetic, all signed:
  - dHx = (RTx−LTx) << (7−log2W); dHy = (RTy−LTy) << (7−log2W).
  - 6-param: dVx = (LBx−LTx) << (7−log2H); dVy = (LBy−LTy) << (7−log2H).
  - 4-param: dVx = −dHy; dVy = dHx.
  - Initial accumulator at subblock centre (2,2): accX = (LTx<<7) + 2·dHx + 2·dVx; accY likewise with dHy/dVy.
- Stepping, incremental with no multipliers in EMIT:
  - Next column: acc += 4·dH.
  - New row: a row-start register adds 4·dV; acc reloads from it.
- Output conversion per component:
  - r = (v + 64) >> 7 for v ≥ 0; r = −((−v + 64) >> 7) for v < 0.
  - Then saturate to [−4096, 4095].
- Order: raster, `sb_x` fastest. Total subblocks = (W/4)·(H/4), i.e. 4..1024.

## Timing
- Reset values: `sb_valid`=0, `sb_last`=0, `busy`=0, `done`=0, `sb_x`=`sb_y`=0, `sb_mv_x`=`sb_mv_y`=0, FSM=IDLE.
- Reset assertion mid-operation clears all state immediately (asynchronous). No `done` is produced for the aborted block.
- `start` high at edge N: `busy`=1 from N+1. First `sb_valid`=1 with subblock (0,0) at N+2.
- All outputs are registered.
- Handshake occurs on an edge where `sb_valid`&&`sb_ready`.
  - Next subblock appears in the following cycle: 1 subblock/cycle at full throughput.
  - While `sb_ready`=0, `sb_x`, `sb_y`, `sb_mv_*` and `sb_last` hold stable and `sb_valid` stays 1.
- `sb_valid` never drops without a handshake.
- Last handshake at edge M: `sb_valid`=0, `busy`=0 and `done`=1 during cycle M+1. `start` is accepted again from M+2.
- Minimum block latency with `sb_ready` tied high: 2 + (W/4)(H/4) cycles from start to `done`.

## Test plan
- Translational case: 128x128, 4-param, all CPMVs (−92,−20), `sb_ready`=1.
  - Expect 1024 subblocks, all (−92,−20).
  - `sb_last` only at (31,31); `done` 1026 cycles after start.
- 4-param zoom: 8x8, LT=(0,0), RT=(16,0).
  - Expect (0,0)→(4,4), (1,0)→(12,4), (0,1)→(4,12), (1,1)→(12,12).
- 6-param: 16x8, LT=RT=(0,0), LB=(0,32).
  - Expect 8 subblocks: row 0 all (0,8), row 1 all (0,24).
- Negative rounding: 8x8, 4-param, LT=(0,0), RT=(−3,0).
  - Expect (0,0)→(−1,−1), (1,0)→(−2,−1), (0,1)→(−1,−2), (1,1)→(−2,−2).
- Saturation: 8x8, 4-param, LT=(4000,0), RT=(4000,−200).
  - Expect (0,0)→(4050,−50), (1,0)→(4050,−150), (0,1)→(4095,−50), (1,1)→(4095,−150).
- Backpressure and reset:
  - Random `sb_ready` on the zoom case: outputs hold while stalled, no duplicate or skipped index, `done` once.
  - Second `start` during EMIT is ignored.
  - `rst_n` pulsed mid-EMIT: `sb_valid`/`busy` drop asynchronously, no `done`; a fresh `start` then completes normally.
